// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: sits between a byte-wide host and an SPI master.
// A TX FIFO feeds the master one byte per frame and an RX FIFO collects
// the byte the master returns at the end of each frame.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame in flight; waits for TX data and a free RX slot
// RUN   | master enabled for FRAME_LEN cycles, TX head held on spi_tx_data
// CAPT  | one cycle: master disabled, RX byte pushed, TX head popped
module spi_xfer_ctrl #(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 10
) (
    input  logic                     clk_int,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     tx_full,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [7:0]               spi_tx_data,
    input  logic [7:0]               spi_rx_data,
    output logic                     spi_enable,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err_ovf,
    output logic                     err_udf,
    input  logic                     clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [3:0]    FCNT_LAST = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [3:0] fcnt;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_rptr;
    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [AW-1:0] rx_wptr;
    logic [CW-1:0] tx_cnt_r;
    logic [CW-1:0] rx_cnt_r;
    logic [CW-1:0] tx_cnt_nxt;
    logic [CW-1:0] rx_cnt_nxt;

    logic tx_pop;
    logic tx_push;
    logic rx_push;
    logic rx_pop;
    logic ovf_ev;
    logic udf_ev;
    logic start_idle;
    logic start_capt;

    // The CAPT cycle is the only time the TX head leaves and the RX byte lands.
    assign tx_pop  = (state == CAPT);
    assign rx_push = (state == CAPT);

    // A full TX FIFO still takes a write when the head is leaving this cycle.
    assign tx_push = wr_en && (!tx_full || tx_pop);
    assign ovf_ev  = wr_en && tx_full && !tx_pop;
    assign rx_pop  = rd_en && !rx_empty;
    assign udf_ev  = rd_en && rx_empty;

    assign tx_cnt_nxt = tx_cnt_r + CW'(tx_push) - CW'(tx_pop);
    assign rx_cnt_nxt = rx_cnt_r + CW'(rx_push) - CW'(rx_pop);

    // From IDLE the registered counts decide; from CAPT the counts after this
    // cycle's pop, push and host read decide (tx_cnt_r is at least 1 in CAPT).
    assign start_idle = (tx_cnt_r != '0) && (rx_cnt_r < DEPTH_C);
    assign start_capt = (tx_cnt_r != CW'(1)) && (rx_cnt_nxt < DEPTH_C);

    assign tx_count    = tx_cnt_r;
    assign rx_count    = rx_cnt_r;
    assign tx_full     = (tx_cnt_r == DEPTH_C);
    assign rx_empty    = (rx_cnt_r == '0);
    assign rd_data     = rx_empty ? 8'h00 : rx_mem[rx_rptr];
    assign spi_tx_data = (tx_cnt_r == '0) ? 8'h00 : tx_mem[tx_rptr];

    // State register.
    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame counter: restarts at 0 on every entry into RUN, counts while in RUN.
    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            fcnt <= 4'd0;
        end else if (state_nxt == RUN && state == RUN) begin
            fcnt <= fcnt + 4'd1;
        end else begin
            fcnt <= 4'd0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_idle ? RUN : IDLE;
            RUN:     state_nxt = (fcnt == FCNT_LAST) ? CAPT : RUN;
            CAPT:    state_nxt = start_capt ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        spi_enable = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            RUN: begin
                spi_enable = 1'b1;
                busy       = 1'b1;
            end
            CAPT: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            tx_rptr  <= '0;
            tx_wptr  <= '0;
            tx_cnt_r <= '0;
        end else begin
            if (tx_pop) tx_rptr <= tx_rptr + AW'(1);
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            tx_cnt_r <= tx_cnt_nxt;
        end
    end

    // TX storage; contents are only visible through the count-gated head.
    always_ff @(posedge clk_int) begin
        if (tx_push) tx_mem[tx_wptr] <= wr_data;
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            rx_rptr  <= '0;
            rx_wptr  <= '0;
            rx_cnt_r <= '0;
        end else begin
            if (rx_pop) rx_rptr <= rx_rptr + AW'(1);
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            rx_cnt_r <= rx_cnt_nxt;
        end
    end

    // RX storage; a free slot is guaranteed whenever CAPT pushes.
    always_ff @(posedge clk_int) begin
        if (rx_push) rx_mem[rx_wptr] <= spi_rx_data;
    end

    // Sticky error flags; a clear wins over an error in the same cycle.
    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (clear_err) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (ovf_ev) err_ovf <= 1'b1;
            if (udf_ev) err_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_spi_xfer_ctrl;

    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 10;

    logic       clk_int = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en   = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] rx_xor  = 8'h00;
    logic [7:0] rd_data;
    logic       tx_full;
    logic       rx_empty;
    logic [2:0] tx_count;
    logic [2:0] rx_count;
    logic [7:0] spi_tx_data;
    logic [7:0] spi_rx_data;
    logic       spi_enable;
    logic       busy;
    logic       frame_done;
    logic       err_ovf;
    logic       err_udf;

    int n_tests = 0;
    int n_fail  = 0;

    // Master stand-in: returns the byte it was given, optionally scrambled.
    assign spi_rx_data = spi_tx_data ^ rx_xor;

    spi_xfer_ctrl #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk_int(clk_int), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .tx_full(tx_full), .rx_empty(rx_empty),
        .tx_count(tx_count), .rx_count(rx_count), .spi_tx_data(spi_tx_data),
        .spi_rx_data(spi_rx_data), .spi_enable(spi_enable), .busy(busy),
        .frame_done(frame_done), .err_ovf(err_ovf), .err_udf(err_udf),
        .clear_err(clear_err)
    );

    always #5 clk_int = ~clk_int;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte queues plus the position inside the frame
    // (-1 idle, 0..FRAME_LEN-1 master enabled, FRAME_LEN capture cycle).
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         pos   = -1;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    initial forever begin : model
        int tx_n;
        int rx_n;
        int rx_after;
        bit capt;
        bit wr_ok;
        bit rd_ok;
        @(posedge clk_int or posedge reset);
        if (reset) begin
            txq.delete();
            rxq.delete();
            pos   = -1;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            tx_n  = txq.size();
            rx_n  = rxq.size();
            capt  = (pos == FRAME_LEN);
            wr_ok = wr_en && (tx_n < DEPTH || capt);
            rd_ok = rd_en && (rx_n > 0);
            rx_after = rx_n + (capt ? 1 : 0) - (rd_ok ? 1 : 0);
            if (pos < 0)
                pos = (tx_n != 0 && rx_n < DEPTH) ? 0 : -1;
            else if (pos < FRAME_LEN)
                pos = pos + 1;
            else
                pos = (tx_n - 1 != 0 && rx_after < DEPTH) ? 0 : -1;
            if (rd_ok) void'(rxq.pop_front());
            if (capt) begin
                rxq.push_back(txq[0] ^ rx_xor);
                void'(txq.pop_front());
            end
            if (wr_ok) txq.push_back(wr_data);
            if (clear_err) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (wr_en && !wr_ok) m_ovf = 1'b1;
                if (rd_en && rx_n == 0) m_udf = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk_int);
        if (!reset) begin
            chk("m_tx_count", tx_count, txq.size());
            chk("m_rx_count", rx_count, rxq.size());
            chk("m_tx_full", tx_full, txq.size() == DEPTH);
            chk("m_rx_empty", rx_empty, rxq.size() == 0);
            chk("m_rd_data", rd_data, (rxq.size() != 0) ? rxq[0] : 8'h00);
            chk("m_spi_tx_data", spi_tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
            chk("m_spi_enable", spi_enable, pos >= 0 && pos < FRAME_LEN);
            chk("m_busy", busy, pos >= 0);
            chk("m_frame_done", frame_done, pos == FRAME_LEN);
            chk("m_err_ovf", err_ovf, m_ovf);
            chk("m_err_udf", err_udf, m_udf);
        end
    end

    // Activity monitor for frame-shape checks.
    int cyc = 0, en_cnt = 0, done_cnt = 0, busy_cnt = 0, first_b = -1, last_b = -1;
    initial forever begin
        @(negedge clk_int);
        if (!reset) begin
            cyc++;
            if (spi_enable) en_cnt++;
            if (frame_done) done_cnt++;
            if (busy) begin
                busy_cnt++;
                if (first_b < 0) first_b = cyc;
                last_b = cyc;
            end
        end
    end

    task automatic clear_mon();
        en_cnt = 0; done_cnt = 0; busy_cnt = 0; first_b = -1; last_b = -1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk_int);
        wr_en = 1'b1;
        wr_data = d;
        @(negedge clk_int);
        wr_en = 1'b0;
    endtask

    task automatic read_pulse();
        @(negedge clk_int);
        rd_en = 1'b1;
        @(negedge clk_int);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk_int);
        clear_err = 1'b1;
        @(negedge clk_int);
        clear_err = 1'b0;
    endtask

    // Wait until no frame is running and none can start.
    task automatic wait_quiet(input string nm, input int maxc);
        int g;
        g = 0;
        while ((busy || (tx_count != 0 && rx_count < DEPTH)) && g < maxc) begin
            @(negedge clk_int);
            g++;
        end
        chk(nm, g < maxc, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        repeat (3) @(negedge clk_int);
        chk("rst_busy", busy, 1'b0);
        chk("rst_spi_enable", spi_enable, 1'b0);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_spi_tx_data", spi_tx_data, 8'h00);
        @(negedge clk_int);
        reset = 1'b0;
        repeat (2) @(negedge clk_int);
        chk("idle_no_start", busy, 1'b0);

        // Single looped-back frame.
        clear_mon();
        write_byte(8'hA5);
        wait_quiet("single_timeout", 100);
        chk("single_en_cycles", en_cnt, 10);
        chk("single_done_pulses", done_cnt, 1);
        chk("single_busy_cycles", busy_cnt, 11);
        chk("single_rx_count", rx_count, 1);
        chk("single_rd_data", rd_data, 8'hA5);
        chk("single_tx_count", tx_count, 0);
        read_pulse();
        chk("single_rx_drained", rx_empty, 1'b1);

        // Underflow on empty RX.
        read_pulse();
        chk("udf_flag", err_udf, 1'b1);
        chk("udf_rd_data", rd_data, 8'h00);
        pulse_clear();
        chk("udf_cleared", err_udf, 1'b0);

        // Back-to-back frames.
        clear_mon();
        @(negedge clk_int); wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk_int); wr_data = 8'h22;
        @(negedge clk_int); wr_data = 8'h33;
        @(negedge clk_int); wr_en = 1'b0;
        wait_quiet("b2b_timeout", 200);
        chk("b2b_en_cycles", en_cnt, 30);
        chk("b2b_done_pulses", done_cnt, 3);
        chk("b2b_busy_cycles", busy_cnt, 33);
        chk("b2b_span", last_b - first_b + 1, 33);
        chk("b2b_rd0", rd_data, 8'h11);
        read_pulse();
        chk("b2b_rd1", rd_data, 8'h22);
        read_pulse();
        chk("b2b_rd2", rd_data, 8'h33);
        read_pulse();
        chk("b2b_empty", rx_empty, 1'b1);

        // Fill RX, then overflow TX while starts are blocked.
        @(negedge clk_int); wr_en = 1'b1; wr_data = 8'h01;
        @(negedge clk_int); wr_data = 8'h02;
        @(negedge clk_int); wr_data = 8'h03;
        @(negedge clk_int); wr_data = 8'h04;
        @(negedge clk_int); wr_en = 1'b0;
        wait_quiet("fill_timeout", 200);
        chk("fill_rx_count", rx_count, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_int);
            if (i == 4) begin
                chk("ovf_full_after4", tx_full, 1'b1);
                chk("ovf_not_yet", err_ovf, 1'b0);
            end
            wr_en = 1'b1;
            wr_data = 8'hA0 + 8'(i);
        end
        @(negedge clk_int);
        wr_en = 1'b0;
        chk("ovf_flag", err_ovf, 1'b1);
        chk("ovf_tx_count", tx_count, 4);
        chk("bp_idle", busy, 1'b0);
        chk("bp_spi_enable", spi_enable, 1'b0);
        pulse_clear();
        chk("ovf_cleared", err_ovf, 1'b0);
        chk("bp_still_idle", busy, 1'b0);

        // One read frees a slot and the next frame begins.
        read_pulse();
        chk("bp_rx_after_read", rx_count, 3);
        @(negedge clk_int);
        chk("bp_run_started", spi_enable, 1'b1);
        chk("bp_head", spi_tx_data, 8'hA0);
        wait_quiet("bp_timeout", 100);
        chk("bp_rx_full_again", rx_count, 4);
        chk("bp_tx_left", tx_count, 3);

        // Write into a full TX exactly on the capture cycle.
        write_byte(8'hB7);
        chk("coinc_full", tx_full, 1'b1);
        read_pulse();
        g = 0;
        while (!frame_done && g < 30) begin
            @(negedge clk_int);
            g++;
        end
        chk("coinc_capt_seen", frame_done, 1'b1);
        wr_en = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk_int);
        wr_en = 1'b0;
        chk("coinc_tx_count", tx_count, 4);
        chk("coinc_no_ovf", err_ovf, 1'b0);
        chk("coinc_rx_count", rx_count, 4);

        // Drain everything, reading whenever RX holds data.
        for (g = 0; g < 400; g++) begin
            @(negedge clk_int);
            if (rx_empty && tx_count == 0 && !busy) break;
            rd_en = !rx_empty;
        end
        rd_en = 1'b0;
        chk("drain_done", g < 400, 1'b1);

        // Returned byte differs from the sent one.
        rx_xor = 8'h3C;
        clear_mon();
        write_byte(8'h77);
        wait_quiet("xor_timeout", 100);
        chk("xor_rd_data", rd_data, 8'h4B);
        chk("xor_en_cycles", en_cnt, 10);
        read_pulse();
        rx_xor = 8'h00;

        // Reset in the middle of a frame.
        write_byte(8'h99);
        g = 0;
        while (!spi_enable && g < 10) begin
            @(negedge clk_int);
            g++;
        end
        chk("midrst_run_seen", spi_enable, 1'b1);
        repeat (5) @(negedge clk_int);
        #1 reset = 1'b1;
        #1;
        chk("midrst_spi_enable", spi_enable, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_frame_done", frame_done, 1'b0);
        chk("midrst_tx_count", tx_count, 0);
        chk("midrst_rx_count", rx_count, 0);
        chk("midrst_rx_empty", rx_empty, 1'b1);
        chk("midrst_rd_data", rd_data, 8'h00);
        chk("midrst_spi_tx_data", spi_tx_data, 8'h00);
        @(negedge clk_int);
        reset = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk_int);
        chk("postrst_no_start", busy_cnt, 0);
        write_byte(8'hC3);
        wait_quiet("postrst_timeout", 100);
        chk("postrst_en_cycles", en_cnt, 10);
        chk("postrst_rd_data", rd_data, 8'hC3);
        chk("postrst_rx_count", rx_count, 1);

        repeat (2) @(negedge clk_int);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
